// File: rtl/alu_st_arbiter.sv
// Round-robin arbiter sharing one two-operand streaming unit among N_REQ requesters.
// Optional `ALU_ST_ARB_LOCK_EN adds req_lock for repeated grants to one requester.
module alu_st_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int ORD_DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*DATA_W-1:0]   req_a,
    input  logic [N_REQ*DATA_W-1:0]   req_b,
`ifdef ALU_ST_ARB_LOCK_EN
    input  logic [N_REQ-1:0]          req_lock,
`endif
    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      a_valid,
    input  logic                      a_ready,
    output logic [DATA_W-1:0]         a_data,
    output logic                      b_valid,
    input  logic                      b_ready,
    output logic [DATA_W-1:0]         b_data,
    input  logic                      r_valid,
    output logic                      r_ready,
    input  logic [DATA_W-1:0]         r_data
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int PTR_W = $clog2(ORD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state;
    logic [ID_W-1:0] rr;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] rr_next;
    logic [ID_W:0]   idx;
    logic            gnt_any;
    logic            accept;
    logic            a_left;
    logic            b_left;

    logic [ID_W-1:0]  fifo [ORD_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [ID_W-1:0]  head;
    logic             full;
    logic             empty;
    logic             pop;

`ifdef ALU_ST_ARB_LOCK_EN
    logic            lock_vld;
    logic [ID_W-1:0] lock_id;
    logic            lock_hit;
    assign lock_hit = lock_vld && req_valid[lock_id];
`endif

    // First valid requester at or after rr, wrapping at N_REQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = rr;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, rr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(N_REQ))
                idx = idx - (ID_W+1)'(N_REQ);
            if (!gnt_any && req_valid[idx[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = idx[ID_W-1:0];
            end
        end
`ifdef ALU_ST_ARB_LOCK_EN
        if (lock_hit) begin
            gnt_any = 1'b1;
            gnt_id  = lock_id;
        end
`endif
    end

    assign rr_next = (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + ID_W'(1);
    assign accept  = reset && (state == IDLE) && !full && gnt_any;

    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[gnt_id] = 1'b1;
    end

    assign head    = fifo[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(ORD_DEPTH));
    assign r_ready = !empty && rsp_ready[head];
    assign pop     = r_valid && r_ready;
    assign rsp_data = r_data;

    always_comb begin
        rsp_valid = '0;
        if (r_valid && !empty)
            rsp_valid[head] = 1'b1;
    end

    assign a_left = a_valid && !a_ready;
    assign b_left = b_valid && !b_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rr      <= '0;
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            a_data  <= '0;
            b_data  <= '0;
`ifdef ALU_ST_ARB_LOCK_EN
            lock_vld <= 1'b0;
            lock_id  <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_data  <= req_a[gnt_id*DATA_W +: DATA_W];
                        b_data  <= req_b[gnt_id*DATA_W +: DATA_W];
                        a_valid <= 1'b1;
                        b_valid <= 1'b1;
                        state   <= ISSUE;
`ifdef ALU_ST_ARB_LOCK_EN
                        lock_vld <= req_lock[gnt_id];
                        lock_id  <= gnt_id;
                        if (!req_lock[gnt_id])
                            rr <= rr_next;
`else
                        rr <= rr_next;
`endif
                    end
                end
                ISSUE: begin
                    // Each valid drops on its own handshake; leave once both are gone.
                    a_valid <= a_left;
                    b_valid <= b_left;
                    if (!a_left && !b_left)
                        state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (accept)
            fifo[wr_ptr] <= gnt_id;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
